// File: rtl/hub75_pixel_loader.sv
// Raster pixel stream to frame-buffer write strobes; write lands one cycle after its beat.
// Ready follows i_enable combinationally; dropping enable aborts the frame and returns to IDLE.
module hub75_pixel_loader #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8,
  localparam int addr_width_p = $clog2(hpixel_p*vpixel_p)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  input  logic [3*bpp_p-1:0]      i_s_data,
  input  logic                    i_s_sof,
  input  logic                    i_s_eol,
  output logic [addr_width_p-1:0] o_wr_addr,
  output logic [3*bpp_p-1:0]      o_wr_data,
  output logic                    o_wr_en,
  output logic                    o_frame_done,
  output logic                    o_busy,
  output logic                    o_err_line,
  output logic                    o_err_frame,
  input  logic                    i_clear_err
);

  localparam int xw_p = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int yw_p = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
  localparam logic [xw_p-1:0]         x_last_c = xw_p'(hpixel_p - 1);
  localparam logic [yw_p-1:0]         y_last_c = yw_p'(vpixel_p - 1);
  localparam logic [addr_width_p-1:0] hstep_c  = addr_width_p'(hpixel_p);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [xw_p-1:0]         x_q, x_d;
  logic [yw_p-1:0]         y_q, y_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [addr_width_p-1:0] base_q, base_d;
  logic                    wr_en_q, wr_en_d;
  logic [addr_width_p-1:0] wr_addr_q, wr_addr_d;
  logic [3*bpp_p-1:0]      wr_data_q, wr_data_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_line_q, err_line_d;
  logic                    err_frame_q, err_frame_d;

  logic                    beat;
  logic                    take;
  logic                    at_last;
  logic [xw_p-1:0]         cur_x;
  logic [yw_p-1:0]         cur_y;
  logic [addr_width_p-1:0] cur_addr;
  logic [addr_width_p-1:0] cur_base;

  assign o_s_ready = i_enable;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_line_d   = i_clear_err ? 1'b0 : err_line_q;
    err_frame_d  = i_clear_err ? 1'b0 : err_frame_q;
    beat         = i_s_valid & i_enable;
    take         = 1'b0;
    at_last      = 1'b0;
    cur_x        = x_q;
    cur_y        = y_q;
    cur_addr     = addr_q;
    cur_base     = base_q;

    if (!i_enable) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      base_d  = '0;
    end else if (beat) begin
      // SOF always rebases the position to pixel (0,0) before the line rules apply
      if (i_s_sof) begin
        take     = 1'b1;
        cur_x    = '0;
        cur_y    = '0;
        cur_addr = '0;
        cur_base = '0;
        if (state_q == ACTIVE) begin
          err_frame_d = 1'b1;
        end
      end else if (state_q == ACTIVE) begin
        take = 1'b1;
      end

      if (take) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cur_addr;
        wr_data_d = i_s_data;
        at_last   = (cur_x == x_last_c);
        if (i_s_eol != at_last) begin
          err_line_d = 1'b1;
        end
        if (i_s_eol || at_last) begin
          if (cur_y == y_last_c) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
            x_d          = '0;
            y_d          = '0;
            addr_d       = '0;
            base_d       = '0;
          end else begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = cur_y + yw_p'(1);
            base_d  = cur_base + hstep_c;
            addr_d  = cur_base + hstep_c;
          end
        end else begin
          state_d = ACTIVE;
          x_d     = cur_x + xw_p'(1);
          y_d     = cur_y;
          base_d  = cur_base;
          addr_d  = cur_addr + addr_width_p'(1);
        end
      end
    end

    // a new error in the same cycle as a clear must survive
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      err_line_q   <= err_line_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q == ACTIVE);
  assign o_err_line   = err_line_q;
  assign o_err_frame  = err_frame_q;

endmodule

// File: tb/tb_hub75_pixel_loader.sv
// Bench for hub75_pixel_loader: directed test-plan scenarios then random traffic against a position model.
module tb_hub75_pixel_loader;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int B  = 8;
  localparam int AW = $clog2(H*V);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_s_valid = 1'b0;
  logic          o_s_ready;
  logic [3*B-1:0] i_s_data = '0;
  logic          i_s_sof = 1'b0;
  logic          i_s_eol = 1'b0;
  logic [AW-1:0] o_wr_addr;
  logic [3*B-1:0] o_wr_data;
  logic          o_wr_en;
  logic          o_frame_done;
  logic          o_busy;
  logic          o_err_line;
  logic          o_err_frame;
  logic          i_clear_err = 1'b0;

  always #5 clk = ~clk;

  hub75_pixel_loader #(.hpixel_p(H), .vpixel_p(V), .bpp_p(B)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_s_valid(i_s_valid),
    .o_s_ready(o_s_ready), .i_s_data(i_s_data), .i_s_sof(i_s_sof), .i_s_eol(i_s_eol),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
    .o_frame_done(o_frame_done), .o_busy(o_busy), .o_err_line(o_err_line),
    .o_err_frame(o_err_frame), .i_clear_err(i_clear_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pixel position (mx,my) inside the frame, address computed as my*H+mx
  bit m_active, m_err_line, m_err_frame;
  int m_x, m_y;
  bit e_wr_en, e_done;
  int e_addr;
  logic [3*B-1:0] e_data;

  task automatic model_reset();
    m_active = 0; m_err_line = 0; m_err_frame = 0; m_x = 0; m_y = 0;
    e_wr_en = 0; e_done = 0; e_addr = 0; e_data = '0;
  endtask

  task automatic model_step(input bit en, input bit vld, input logic [3*B-1:0] dat,
                            input bit sof, input bit eol, input bit clr);
    bit w;
    bit line_end;
    e_wr_en = 0;
    e_done  = 0;
    if (clr) begin
      m_err_line  = 0;
      m_err_frame = 0;
    end
    if (!en) begin
      m_active = 0; m_x = 0; m_y = 0;
    end else if (vld) begin
      w = 0;
      if (sof) begin
        if (m_active) m_err_frame = 1;
        m_x = 0; m_y = 0; w = 1;
      end else if (m_active) begin
        w = 1;
      end
      if (w) begin
        e_wr_en = 1;
        e_addr  = m_y * H + m_x;
        e_data  = dat;
        line_end = (m_x == H - 1);
        if (eol != line_end) m_err_line = 1;
        if (eol || line_end) begin
          if (m_y == V - 1) begin
            e_done = 1; m_active = 0; m_x = 0; m_y = 0;
          end else begin
            m_active = 1; m_x = 0; m_y = m_y + 1;
          end
        end else begin
          m_active = 1; m_x = m_x + 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("wr_en", o_wr_en, e_wr_en);
    check("wr_addr", o_wr_addr, e_addr);
    check("wr_data", o_wr_data, e_data);
    check("frame_done", o_frame_done, e_done);
    check("busy", o_busy, m_active);
    check("err_line", o_err_line, m_err_line);
    check("err_frame", o_err_frame, m_err_frame);
  endtask

  task automatic cycle(input bit en, input bit vld, input logic [3*B-1:0] dat,
                       input bit sof, input bit eol, input bit clr);
    @(negedge clk);
    i_enable = en; i_s_valid = vld; i_s_data = dat; i_s_sof = sof; i_s_eol = eol; i_clear_err = clr;
    #1;
    check("ready", o_s_ready, en);
    model_step(en, vld, dat, sof, eol, clr);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic beat(input bit sof, input bit eol);
    cycle(1, 1, 24'($urandom), sof, eol, 0);
  endtask

  task automatic nominal_frame();
    for (int i = 0; i < H*V; i++) beat(i == 0, (i % H) == H - 1);
  endtask

  task automatic reset_mid(input bit keep_low_cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wr_en", o_wr_en, 0);
    check("rst_addr", o_wr_addr, 0);
    check("rst_data", o_wr_data, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err_line", o_err_line, 0);
    check("rst_err_frame", o_err_frame, 0);
    if (keep_low_cycles) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit en, vld, sof, eol, clr;
    model_reset();
    #1;
    check("init_ready", o_s_ready, 0);
    reset_mid(1);

    // nominal frame, with explicit last-write expectations
    nominal_frame();
    check("nom_last_addr", o_wr_addr, H*V - 1);
    check("nom_last_done", o_frame_done, 1);
    cycle(1, 0, '0, 0, 0, 0);

    // garbage before SOF is dropped
    for (int i = 0; i < 3; i++) beat(0, 0);
    nominal_frame();

    // early EOL on second pixel of line 0; next beat lands at H
    beat(1, 0);
    beat(0, 1);
    check("early_eol_flag", o_err_line, 1);
    beat(0, 0);
    check("early_eol_next_addr", o_wr_addr, H);
    for (int i = 1; i < H; i++) beat(0, i == H - 1);

    // error clear
    cycle(1, 0, '0, 0, 0, 1);
    check("clear_err_line", o_err_line, 0);

    // SOF on the 6th beat restarts the frame
    for (int i = 0; i < 5; i++) beat(i == 0, (i % H) == H - 1);
    beat(1, 0);
    check("mid_sof_flag", o_err_frame, 1);
    check("mid_sof_addr", o_wr_addr, 0);
    beat(0, 0);
    check("mid_sof_next", o_wr_addr, 1);
    beat(0, 0);
    beat(0, 1);
    cycle(1, 0, '0, 0, 0, 1);

    // enable dropped mid-frame while the source keeps offering
    for (int i = 0; i < 3; i++) beat(i == 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 24'($urandom), 0, 0, 0);
    nominal_frame();

    // set and clear in the same cycle: set wins
    beat(1, 1);
    cycle(1, 1, 24'($urandom), 0, 1, 1);
    check("set_beats_clear", o_err_line, 1);

    // async reset mid-frame, then a fresh frame from address 0
    beat(0, 0);
    reset_mid(0);
    nominal_frame();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom % 20) != 0;
      vld = ($urandom % 4) != 0;
      sof = m_active ? (($urandom % 40) == 0) : (($urandom % 3) == 0);
      eol = (m_x == H - 1) ? (($urandom % 10) != 0) : (($urandom % 15) == 0);
      clr = ($urandom % 50) == 0;
      cycle(en, vld, 24'($urandom), sof, eol, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hub75_pixel_loader.md
Name: hub75_pixel_loader

Overview:
- Upstream feeder for the HUB75 driver's frame buffer write port.
- Accepts a raster-ordered pixel stream with valid/ready handshake, start-of-frame and end-of-line markers.
- Converts the stream into write address, data and enable strobes for the frame buffer.
- Tracks line/frame position, realigns on malformed input and reports framing errors through sticky flags.

Parameters:
- hpixel_p, 64, display width in pixels.
- vpixel_p, 64, display height in pixels.
- bpp_p, 8, bits per colour channel.
- addr_width_p (localparam), $clog2(hpixel_p*vpixel_p), frame buffer address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  loader enable; low aborts any frame in progress.
- i_s_valid  in  1  stream pixel valid.
- o_s_ready  out  1  stream ready.
- i_s_data  in  3*bpp_p  pixel packed {R,G,B}.
- i_s_sof  in  1  beat is first pixel of a frame.
- i_s_eol  in  1  beat is last pixel of a line.
- o_wr_addr  out  addr_width_p  frame buffer write address.
- o_wr_data  out  3*bpp_p  frame buffer write data {R,G,B}.
- o_wr_en  out  1  frame buffer write enable.
- o_frame_done  out  1  one-cycle pulse on the final write of a frame.
- o_busy  out  1  high while in ACTIVE.
- o_err_line  out  1  sticky flag: EOL position mismatch.
- o_err_frame  out  1  sticky flag: SOF seen mid-frame.
- i_clear_err  in  1  clears both sticky error flags.

Behaviour:
- Reset: all outputs are 0; state is IDLE; x, y and address counters are 0.
- Beat definition: a beat is i_s_valid & o_s_ready. o_s_ready = i_enable (registered-free combinational). Data and markers are sampled only on beats.
- Write timing: each written beat produces o_wr_en=1 exactly one cycle later, with registered o_wr_addr/o_wr_data. o_wr_en is 0 otherwise; addr/data hold their last value.
- Addressing: addr = y*hpixel_p + x. This is maintained by an incrementing address register plus a line-base register; no multiplier.
- State IDLE:
  - SOF beat: write at addr 0, then x=1, y=0, go to ACTIVE.
  - Non-SOF beat: dropped, no write.
- State ACTIVE, per beat, evaluated in priority order:
  1. SOF: set err_frame; restart the frame by writing at addr 0, then x=1, y=0.
  2. Line end (EOL with x==hpixel_p-1): write the pixel.
     - If y==vpixel_p-1: pulse o_frame_done together with this write's o_wr_en, then go to IDLE.
     - Otherwise: x=0, y=y+1.
  3. Early EOL (x<hpixel_p-1): set err_line; write the pixel; remaining pixels of the line stay unwritten. Advance to the next line, or finish the frame as in rule 2 if y==vpixel_p-1.
  4. Missing EOL (x==hpixel_p-1 without EOL): set err_line; treat as an implicit EOL, applying identical line/frame advance.
  5. Otherwise: write the pixel, x=x+1.
- Single-pixel stream: a beat with SOF and EOL both set in IDLE follows the same rules. Write at 0; if hpixel_p>1, set err_line and advance to line 1.
- i_enable low: no beats are accepted. State returns to IDLE on the next clock and counters clear. A write already registered still completes its o_wr_en cycle.
- Error flags: sticky until i_clear_err. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-frame: state returns to IDLE immediately and asynchronously; no partial write is issued.

Test Plan:
- Nominal frame (hpixel_p=4, vpixel_p=2): SOF beat, 8 beats, EOL on beats 4 and 8 -> writes to addrs 0..7 with matching data, each one cycle after its beat; o_frame_done high with the addr-7 write; errors stay 0.
- Pre-SOF garbage: 3 beats without SOF, then a nominal frame -> the 3 beats produce no writes; frame is written at 0..7.
- Early EOL: EOL on the 2nd pixel of line 0 -> err_line=1; the next beat is written at addr 4.
- Mid-frame SOF: SOF on the 6th beat -> err_frame=1; that beat is written at addr 0, and subsequent writes continue at 1, 2, ...
- Backpressure/abort: drop i_enable after 3 beats, raise it again, send a full frame -> o_s_ready=0 while disabled; no writes while disabled; the new frame starts at addr 0.
- Error clear and reset: assert i_clear_err while err_line is set -> flag clears the next cycle. Assert rst_n low mid-frame -> all outputs 0; the next SOF is written at addr 0.
